// File: rtl/dbus_arbiter_pkg.sv
// Shared data-bus request/response types and arbiter state encoding.
// Imported by the arbiter top and its round-robin picker.
package dbus_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef logic [2:0] msize_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        msize_t            size;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] data;
    } dbus_resp_t;

    typedef enum logic {ARB_IDLE, ARB_BUSY} dbus_arb_state_t;

    // Requester index examined at priority position 'offset' when 'last' was granted most recently.
    function automatic int rr_slot(input int last, input int offset, input int n);
        return (last + 1 + offset) % n;
    endfunction

endpackage

// File: rtl/dbus_arbiter_rr_picker.sv
// Rotating-priority encoder: picks the first asserted valid starting just after 'last'.
// Purely combinational so the ibus arbiter can reuse it unchanged.
module rr_picker
    import dbus_arbiter_pkg::*;
#(
    parameter int N = 2,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0]     rot_valid;
    logic [N:0]       seen;
    logic [N-1:0]     sel;
    logic [IDX_W-1:0] acc [N+1];

    assign seen[0] = 1'b0;
    assign acc[0]  = '0;

    // rot_valid[0] is the highest-priority slot; a one-hot select then folds back to an index.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            assign rot_valid[gi] = valid[IDX_W'(rr_slot(int'(last), gi, N))];
            assign sel[gi]       = rot_valid[gi] & ~seen[gi];
            assign seen[gi+1]    = seen[gi] | rot_valid[gi];
            assign acc[gi+1]     = acc[gi] | (sel[gi] ? IDX_W'(rr_slot(int'(last), gi, N)) : '0);
        end
    endgenerate

    assign any = seen[N];
    assign idx = acc[N];

endmodule

// File: rtl/dbus_arbiter.sv
// Round-robin arbiter sharing one D-cache data-bus port among NUM_REQ requesters,
// with one registered outstanding transaction so upstream flushes cannot disturb it.
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  dbus_req_t  [NUM_REQ-1:0]   ireqs,
    output dbus_resp_t [NUM_REQ-1:0]   oresps,
    output dbus_req_t                  oreq,
    input  dbus_resp_t                 iresp
);

    dbus_arb_state_t  state_reg, state_next;
    logic [IDX_W-1:0] owner_reg, owner_next;
    logic [IDX_W-1:0] last_reg, last_next;
    logic             aborted_reg, aborted_next;
    dbus_req_t        held_reg, held_next;

    logic [NUM_REQ-1:0] req_valid;
    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_valid;
    logic               unused_iresp_addr_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_valid
            assign req_valid[gi] = ireqs[gi].valid;
        end
    endgenerate

    rr_picker #(.N(NUM_REQ)) u_picker (
        .valid (req_valid),
        .last  (last_reg),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    assign owner_valid = req_valid[owner_reg];
    // Upstream only ever sees addr_ok together with data_ok, so the cache's addr_ok is ignored.
    assign unused_iresp_addr_ok = iresp.addr_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ARB_IDLE;
            owner_reg   <= '0;
            last_reg    <= IDX_W'(NUM_REQ - 1);
            aborted_reg <= 1'b0;
            held_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            last_reg    <= last_next;
            aborted_reg <= aborted_next;
            held_reg    <= held_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        last_next    = last_reg;
        aborted_next = aborted_reg;
        held_next    = held_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (pick_any) begin
                    held_next    = ireqs[pick_idx];
                    owner_next   = pick_idx;
                    last_next    = pick_idx;
                    aborted_next = 1'b0;
                    state_next   = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // Once the owner lets go, any later re-request is a new access, not this one.
                if (!owner_valid) begin
                    aborted_next = 1'b1;
                end
                if (iresp.data_ok) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        oreq   = '0;
        oresps = '0;
        if (state_reg == ARB_BUSY) begin
            oreq       = held_reg;
            oreq.valid = 1'b1;
            if (iresp.data_ok && !aborted_reg && owner_valid) begin
                oresps[owner_reg].addr_ok = 1'b1;
                oresps[owner_reg].data_ok = 1'b1;
                oresps[owner_reg].data    = iresp.data;
            end
        end
    end

endmodule
